// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, state codes and value helpers for the mini CPU
package cpu_pkg;

    localparam int REG_W  = 16;
    localparam int REG_N  = 16;
    localparam int REG_AW = 4;

    localparam int OPC_MSB = 17;
    localparam int OPC_LSB = 15;
    localparam int R1_MSB  = 14;
    localparam int R1_LSB  = 11;
    localparam int R2_MSB  = 10;
    localparam int R2_LSB  = 7;
    localparam int R3_MSB  = 6;
    localparam int R3_LSB  = 3;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [2:0] {
        ST_OFF    = 3'b000,
        ST_IDLE   = 3'b001,
        ST_DECODE = 3'b010,
        ST_EXEC   = 3'b011,
        ST_SHOW   = 3'b101,
        ST_STORE  = 3'b110
    } cpu_state_e;

    // Switch immediates are sign-magnitude; the datapath is two's complement.
    function automatic logic [REG_W-1:0] imm_sext(input logic [6:0] imm);
        logic [REG_W-1:0] mag;
        mag = {10'd0, imm[5:0]};
        return imm[6] ? (16'd0 - mag) : mag;
    endfunction

    function automatic logic [REG_W-1:0] to_sign_mag(input logic [REG_W-1:0] v);
        logic [REG_W-1:0] neg;
        neg = 16'd0 - v;
        if (v == 16'h8000)
            return 16'hFFFF;
        else if (v[15])
            return {1'b1, neg[14:0]};
        else
            return v;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 16x16 register file, two async read ports, one write port, global clear
module reg_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [REG_W-1:0]  wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [REG_W-1:0]  rdata_a,
    output logic [REG_W-1:0]  rdata_b
);

    logic [REG_W-1:0] mem [REG_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < REG_N; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mini_cpu_ctrl.sv
// rtl/mini_cpu_ctrl.sv - mini CPU controller: button conditioning, FSM, ALU, result formatting
module mini_cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int SHOW_HOLD   = 4_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_power,
    input  logic        btn_send,
    input  logic [17:0] instr,
    output logic [2:0]  estadoCpu,
    output logic [2:0]  opcode,
    output logic [15:0] result,
    output logic [3:0]  reg1,
    output logic [3:0]  reg2,
    output logic [3:0]  reg3
);

    localparam int CW = (SHOW_HOLD < 2) ? 1 : $clog2(SHOW_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(SHOW_HOLD);

    cpu_state_e          state, state_nxt;
    logic [SYNC_STAGES-1:0] pwr_sync, send_sync;
    logic                pwr_prev, send_prev, pwr_pulse, send_pulse;
    logic                load_fields, rf_we, rf_clr;
    logic [REG_AW-1:0]   rf_waddr;
    logic [6:0]          imm_q;
    logic [REG_W-1:0]    imm_ext, rd_a, rd_b, op_a, op_b, alu_val, alu_q;
    logic [CW-1:0]       hold_cnt;

    // Registered edge detect: the pulse lands one cycle after the last sync stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_sync   <= '0;
            send_sync  <= '0;
            pwr_prev   <= 1'b0;
            send_prev  <= 1'b0;
            pwr_pulse  <= 1'b0;
            send_pulse <= 1'b0;
        end else begin
            pwr_sync   <= SYNC_STAGES'({pwr_sync, btn_power});
            send_sync  <= SYNC_STAGES'({send_sync, btn_send});
            pwr_prev   <= pwr_sync[SYNC_STAGES-1];
            send_prev  <= send_sync[SYNC_STAGES-1];
            pwr_pulse  <= pwr_sync[SYNC_STAGES-1] & ~pwr_prev;
            send_pulse <= send_sync[SYNC_STAGES-1] & ~send_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_OFF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_fields = 1'b0;
        rf_we       = 1'b0;
        rf_clr      = 1'b0;
        rf_waddr    = reg2;
        if (state == ST_OFF) begin
            if (pwr_pulse) begin
                state_nxt = ST_IDLE;
                rf_clr    = 1'b1;
            end
        end else if (pwr_pulse) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (send_pulse) begin
                        state_nxt   = ST_DECODE;
                        load_fields = 1'b1;
                    end
                end
                ST_DECODE: state_nxt = ST_EXEC;
                ST_EXEC:   state_nxt = ST_STORE;
                ST_STORE: begin
                    state_nxt = ST_SHOW;
                    rf_clr    = (opcode == OP_CLEAR);
                    rf_we     = (opcode != OP_CLEAR) && (opcode != OP_DISPLAY);
                    case (opcode)
                        OP_LOAD:        rf_waddr = reg1;
                        OP_ADD, OP_SUB: rf_waddr = reg3;
                        default:        rf_waddr = reg2;
                    endcase
                end
                ST_SHOW: begin
                    if (send_pulse && hold_cnt == HOLD_MAX) begin
                        state_nxt   = ST_DECODE;
                        load_fields = 1'b1;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    assign imm_ext = imm_sext(imm_q);

    always_comb begin
        alu_val = '0;
        case (opcode)
            OP_LOAD:  alu_val = imm_ext;
            OP_ADD:   alu_val = op_a + op_b;
            OP_ADDI:  alu_val = op_a + imm_ext;
            OP_SUB:   alu_val = op_a - op_b;
            OP_SUBI:  alu_val = op_a - imm_ext;
            OP_MUL:   alu_val = op_a * imm_ext;
            OP_CLEAR: alu_val = '0;
            default:  alu_val = op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode   <= '0;
            reg1     <= '0;
            reg2     <= '0;
            reg3     <= '0;
            imm_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            alu_q    <= '0;
            result   <= '0;
            hold_cnt <= '0;
        end else begin
            if (load_fields) begin
                opcode <= instr[OPC_MSB:OPC_LSB];
                reg1   <= instr[R1_MSB:R1_LSB];
                reg2   <= instr[R2_MSB:R2_LSB];
                reg3   <= instr[R3_MSB:R3_LSB];
                imm_q  <= instr[IMM_MSB:IMM_LSB];
            end
            if (state == ST_DECODE) begin
                op_a <= rd_a;
                op_b <= rd_b;
            end
            if (state == ST_EXEC) alu_q <= alu_val;
            // A power pulse in STORE aborts the whole commit, display value included.
            if (state == ST_STORE && !pwr_pulse) result <= to_sign_mag(alu_q);
            if (state == ST_STORE)
                hold_cnt <= '0;
            else if (state == ST_SHOW && hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + CW'(1);
        end
    end

    reg_file u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rf_clr),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (alu_q),
        .raddr_a (reg1),
        .raddr_b (reg2),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign estadoCpu = state;

endmodule
